// File: rtl/led_indicator_pkg.sv
// rtl/led_indicator_pkg.sv - shared mode encoding and PWM width for the LED driver
package led_indicator_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'b00,
      LED_ON    = 2'b01,
      LED_BLINK = 2'b10,
      LED_FLASH = 2'b11
   } led_mode_t;

   localparam int PWM_W = 8;

endpackage

// File: rtl/led_indicator_if.sv
// rtl/led_indicator_if.sv - control/drive signal bundle between control logic and the LED driver
interface led_indicator_if #(
   parameter int NUM = 4
);
   import led_indicator_pkg::*;

   logic [2*NUM-1:0] mode_i;
   logic [NUM-1:0]   trig_i;
   logic [PWM_W-1:0] duty_i;
   logic [NUM-1:0]   led_no;
   logic             tick_o;

   modport master (output mode_i, output trig_i, output duty_i, input led_no, input tick_o);
   modport slave  (input mode_i, input trig_i, input duty_i, output led_no, output tick_o);

endinterface

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: flash remaining counter and registered active-low drive
module led_channel
   import led_indicator_pkg::*;
#(
   parameter int FLASH_TICKS = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  led_mode_t mode,
   input  logic      trig,
   input  logic      tick,
   input  logic      phase_nxt,
   input  logic      pwm_ok,
   output logic      led_no
);

   localparam int RW = $clog2(FLASH_TICKS + 1);

   logic [RW-1:0] rem_q;
   logic [RW-1:0] rem_d;
   logic          lit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q  <= '0;
         led_no <= 1'b1;
      end else begin
         rem_q  <= rem_d;
         led_no <= ~lit;
      end
   end

   // A trigger beats a same-cycle tick so the flash always gets its full reload.
   always_comb begin
      rem_d = rem_q;
      if (mode != LED_FLASH)
         rem_d = '0;
      else if (trig)
         rem_d = RW'(FLASH_TICKS);
      else if (tick && rem_q != '0)
         rem_d = rem_q - RW'(1);
   end

   always_comb begin
      lit = 1'b0;
      unique case (mode)
         LED_OFF:   lit = 1'b0;
         LED_ON:    lit = 1'b1;
         LED_BLINK: lit = phase_nxt;
         LED_FLASH: lit = (rem_d != '0);
         default:   lit = 1'b0;
      endcase
      lit = lit & pwm_ok;
   end

endmodule

// File: rtl/led_indicator.sv
// rtl/led_indicator.sv - LED driver top: shared prescaler, blink phase, optional PWM (LED_PWM_EN)
module led_indicator
   import led_indicator_pkg::*;
#(
   parameter int NUM         = 4,
   parameter int DIV         = 4000000,
   parameter int FLASH_TICKS = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   led_indicator_if.slave bus
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          tick;
   logic          phase_q;
   logic          phase_nxt;
   logic          pwm_ok;

   assign tick      = (cnt_q == CW'(DIV - 1));
   assign phase_nxt = phase_q ^ tick;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         bus.tick_o <= 1'b0;
      end else begin
         cnt_q      <= tick ? '0 : cnt_q + CW'(1);
         phase_q    <= phase_nxt;
         bus.tick_o <= tick;
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] pwm_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         pwm_q <= '0;
      else
         pwm_q <= pwm_q + PWM_W'(1);
   end

   assign pwm_ok = (pwm_q < bus.duty_i);
`else
   logic unused_duty;

   assign unused_duty = ^bus.duty_i;
   assign pwm_ok      = 1'b1;
`endif

   for (genvar i = 0; i < NUM; i++) begin : g_ch
      led_channel #(
         .FLASH_TICKS(FLASH_TICKS)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .mode     (led_mode_t'(bus.mode_i[2*i +: 2])),
         .trig     (bus.trig_i[i]),
         .tick     (tick),
         .phase_nxt(phase_nxt),
         .pwm_ok   (pwm_ok),
         .led_no   (bus.led_no[i])
      );
   end

endmodule

// File: tb/tb_led_indicator.sv
// tb/tb_led_indicator.sv - directed and randomized checks of led_indicator against a time-based model
module tb_led_indicator;
   import led_indicator_pkg::*;

   localparam int NUM = 4;
   localparam int DIV = 4;
   localparam int FT  = 2;

   logic clk_i = 1'b0;
   logic rst_ni;

   led_indicator_if #(.NUM(NUM)) bus ();

   led_indicator #(
      .NUM(NUM), .DIV(DIV), .FLASH_TICKS(FT)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Model: n counts clock edges since reset release; ticks are derived arithmetically from n.
   int             n;
   bit             armed [NUM];
   int             end_t [NUM];
   logic [NUM-1:0] exp_led;
   logic           exp_tick;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int c = 0; c < NUM; c++) begin
         armed[c] = 1'b0;
         end_t[c] = 0;
      end
   endtask

   task automatic model_step();
      int         tot;
      logic       lit;
      logic [1:0] m;
      tot      = (n + 1) / DIV;
      exp_tick = ((n % DIV) == DIV - 1);
      for (int c = 0; c < NUM; c++) begin
         m = bus.mode_i[2*c +: 2];
         if (m != 2'b11) armed[c] = 1'b0;
         else if (bus.trig_i[c]) begin
            armed[c] = 1'b1;
            end_t[c] = tot + FT;
         end
         case (m)
            2'b00:   lit = 1'b0;
            2'b01:   lit = 1'b1;
            2'b10:   lit = (tot % 2) == 1;
            default: lit = armed[c] && (tot < end_t[c]);
         endcase
`ifdef LED_PWM_EN
         lit = lit && ((n % 256) < int'(bus.duty_i));
`endif
         exp_led[c] = ~lit;
      end
      n++;
   endtask

   task automatic step(input string tag);
      @(posedge clk_i);
      model_step();
      #1;
      check({tag, "_led"}, 32'(bus.led_no), 32'(exp_led));
      check({tag, "_tick"}, 32'(bus.tick_o), 32'(exp_tick));
   endtask

   task automatic run(input string tag, input int cycles);
      for (int k = 0; k < cycles; k++) step(tag);
   endtask

   task automatic set_mode(input int ch, input led_mode_t m);
      bus.mode_i[2*ch +: 2] = m;
   endtask

   initial begin
      int low_cnt;
      rst_ni     = 1'b0;
      bus.mode_i = '0;
      bus.trig_i = '0;
      bus.duty_i = 8'd255;
      model_reset();
      #12;
      check("reset_led", 32'(bus.led_no), 32'hF);
      check("reset_tick", 32'(bus.tick_o), 32'h0);
      rst_ni = 1'b1;

      // Steady modes
      run("idle", 3);
      set_mode(0, LED_ON);
      step("on");
      check("on_const", 32'(bus.led_no), 32'hE);
      set_mode(0, LED_OFF);
      step("off");
      check("off_const", 32'(bus.led_no), 32'hF);

      // Blink
      set_mode(1, LED_BLINK);
      run("blink", 17);

      // Flash, duration and retrigger
      set_mode(2, LED_FLASH);
      step("flash_arm");
      bus.trig_i[2] = 1'b1;
      step("flash_trig");
      bus.trig_i[2] = 1'b0;
      low_cnt = 1;
      for (int k = 0; k < 12; k++) begin
         step("flash_run");
         if (bus.led_no[2] == 1'b0) low_cnt++;
      end
      check("flash_len_ok", 32'((low_cnt >= 5) && (low_cnt <= 8)), 32'h1);
      bus.trig_i[2] = 1'b1;
      step("retrig_a");
      bus.trig_i[2] = 1'b0;
      run("retrig_wait", 3);
      bus.trig_i[2] = 1'b1;
      step("retrig_b");
      bus.trig_i[2] = 1'b0;
      run("retrig_run", 12);

      // Reset mid-flash: outputs dark immediately, first tick DIV cycles after release
      bus.trig_i[2] = 1'b1;
      step("pre_reset");
      bus.trig_i[2] = 1'b0;
      rst_ni = 1'b0;
      #1;
      check("async_reset_led", 32'(bus.led_no), 32'hF);
      check("async_reset_tick", 32'(bus.tick_o), 32'h0);
      #2;
      rst_ni = 1'b1;
      model_reset();
      set_mode(1, LED_OFF);
      run("post_reset", 3);
      check("no_early_tick", 32'(bus.tick_o), 32'h0);
      step("first_tick");
      check("first_tick_const", 32'(bus.tick_o), 32'h1);

      // Trigger colliding with tick, then cancel and re-entry
      set_mode(3, LED_FLASH);
      for (int k = 0; k < DIV && (n % DIV) != DIV - 1; k++) step("align");
      bus.trig_i[3] = 1'b1;
      step("collide");
      bus.trig_i[3] = 1'b0;
      run("collide_run", 2 * DIV + 2);
      bus.trig_i[3] = 1'b1;
      step("cancel_trig");
      bus.trig_i[3] = 1'b0;
      step("cancel_lit");
      set_mode(3, LED_OFF);
      step("cancel");
      check("cancel_dark", 32'(bus.led_no[3]), 32'h1);
      set_mode(3, LED_FLASH);
      run("reenter", 6);

`ifdef LED_PWM_EN
      bus.mode_i = '0;
      set_mode(0, LED_ON);
      bus.duty_i = 8'd64;
      low_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         step("pwm64");
         if (bus.led_no[0] == 1'b0) low_cnt++;
      end
      check("pwm64_count", 32'(low_cnt), 32'd64);
      bus.duty_i = 8'd0;
      low_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         step("pwm0");
         if (bus.led_no[0] == 1'b0) low_cnt++;
      end
      check("pwm0_count", 32'(low_cnt), 32'd0);
`endif

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0)
            set_mode(int'($urandom_range(0, NUM - 1)), led_mode_t'($urandom_range(0, 3)));
         for (int c = 0; c < NUM; c++)
            bus.trig_i[c] = ($urandom_range(0, 5) == 0);
`ifdef LED_PWM_EN
         if ($urandom_range(0, 31) == 0) bus.duty_i = 8'($urandom_range(0, 255));
`endif
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_indicator.md
# led_indicator

Per-channel LED output driver for the board's indicator LEDs, the output-side counterpart of the debounced push-button input block. It turns per-channel mode selections and one-cycle event pulses, such as button press events, into registered, active-low LED drive signals. Supported modes are off, steady on, blink, and retriggerable flash. It sits between the control logic and the FPGA LED pins.

## Interface
- NUM, 4, number of LED channels (≥1)
- DIV, 4000000, clk_i cycles per prescaler tick (≥1)
- FLASH_TICKS, 2, ticks a channel stays lit after a flash trigger (≥1)
- clk_i  input  1  system clock
- rst_ni  input  1  reset; one clock, reset is asynchronous and active-low
- mode_i  input  2*NUM  per channel i, bits [2i+1:2i]: 00 OFF, 01 ON, 10 BLINK, 11 FLASH
- trig_i  input  NUM  one-cycle flash trigger per channel; ignored unless that channel's mode is FLASH
- duty_i  input  8  PWM brightness for lit channels; used only when LED_PWM_EN is defined
- led_no  output  NUM  LED drive, active-low (0 = lit), registered
- tick_o  output  1  one-cycle pulse per prescaler wrap, registered

## Operation
- Prescaler:
  - Shared counter runs 0..DIV-1 and wraps to 0.
  - tick is true in the cycle where counter == DIV-1.
  - tick_o is tick registered, so it pulses once every DIV cycles.
  - With DIV=1, tick is true every cycle.
- Blink phase:
  - Shared 1-bit register, toggles on each tick.
  - BLINK channels are lit when the phase is 1.
- Per-channel flash remaining counter rem[i]:
  - Width is $clog2(FLASH_TICKS+1).
  - In FLASH mode, trig_i[i] loads FLASH_TICKS. Otherwise, on tick, rem[i] decrements if nonzero.
  - A trigger and a tick in the same cycle: the load wins and rem = FLASH_TICKS.
  - A retrigger while lit reloads, which extends the flash.
  - In any mode other than FLASH, rem[i] is forced to 0. Leaving FLASH cancels an active flash, and re-entering FLASH starts dark.
- Per-channel effective state:
  - OFF: dark.
  - ON: lit.
  - BLINK: lit = phase.
  - FLASH_IDLE (rem == 0): dark.
  - FLASH_ACTIVE (rem != 0): lit.
- Transitions:
  - FLASH_IDLE → FLASH_ACTIVE on trig.
  - FLASH_ACTIVE → FLASH_IDLE on the tick that decrements rem from 1 to 0.
  - Any state → the mode_i state on the next edge.
- Output:
  - led_no[i] is registered from ~lit, where lit is computed from the next-state values of phase, rem and mode_i.
  - All channels are independent. Simultaneous triggers on several channels are all honoured.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Prescaler counter = 0, phase = 0, all rem = 0.
  - led_no = all ones (all LEDs dark).
  - tick_o = 0.
- Reset asserted mid-flash or mid-blink: outputs go dark at once. After release, the first tick occurs DIV cycles later.
- Latency:
  - mode_i change → led_no updates at the next rising edge (1 cycle).
  - trig_i → led_no[i] goes low at the same edge that loads rem.
- Flash duration is between (FLASH_TICKS-1)*DIV+1 and FLASH_TICKS*DIV cycles, depending on prescaler phase at trigger.
- Blink period is 2*DIV cycles with 50 % duty. Blink edges coincide with the edge after tick.
- mode_i is sampled every cycle; there is no handshake. trig_i is edge-free: a level held for N cycles reloads N times.

## Configuration
- LED_PWM_EN defined:
  - Adds a free-running 8-bit pwm counter, reset to 0, wrapping 255 → 0.
  - Final lit = lit & (pwm_cnt < duty_i).
  - duty_i = 0 gives always dark. duty_i = 255 gives lit for 255 of every 256 cycles.
  - duty_i is sampled every cycle.
- LED_PWM_EN undefined:
  - No pwm counter; duty_i is ignored and lit LEDs are fully on.
  - Port list is unchanged.

## Structure
- Package led_indicator_pkg holds:
  - the mode typedef (2-bit enum: LED_OFF, LED_ON, LED_BLINK, LED_FLASH);
  - the PWM width constant (8).
- The prescaler, blink phase and optional PWM counter are shared, and live in the top-level led_indicator.
- One sub-module, led_channel, is generated NUM times. It holds rem and the led_no register, and computes lit from mode, trig, tick, phase and the PWM compare.

## Test plan
Parameters DIV=4 and FLASH_TICKS=2 unless stated.

1. Reset: rst_ni low between edges during an active flash → led_no = 4'b1111 and tick_o = 0 immediately. After release, the first tick_o pulse comes 4 cycles later.
2. Steady modes: mode_i ch0 = ON, others OFF → led_no = 4'b1110 one edge later. Set ch0 = OFF → 4'b1111 one edge later.
3. Blink: ch1 = BLINK → tick_o pulses every 4 cycles. led_no[1] toggles every 4 cycles, giving period 8: 4 cycles low, 4 high.
4. Flash and retrigger: ch2 = FLASH, single trig → led_no[2] low for 5–8 cycles, then high. A retrigger while lit reloads and extends the flash by 2 ticks from the retrigger point.
5. Collision and cancel:
   - trig_i[3] asserted in the same cycle as tick → rem[3] = 2, not 1.
   - Switching ch3 to OFF mid-flash → dark next edge.
   - Switching back to FLASH → stays dark until a new trig.
6. PWM (LED_PWM_EN defined): ch0 = ON with duty_i = 64 → led_no[0] low for exactly 64 of every 256 cycles. duty_i = 0 → never low.
